// File: rtl/fp_wb_buffer_if.sv
// rtl/fp_wb_buffer_if.sv - FP write-back buffer port bundle (producers, register-file write port, hazard query)
interface fp_wb_buffer_if;
    logic        ld_valid;
    logic [0:4]  ld_rd;
    logic [0:63] ld_data;
    logic        ld_is64;

    logic        fp_valid;
    logic        fp_ready;
    logic [0:4]  fp_rd;
    logic [0:63] fp_data;
    logic        fp_is64;

    logic [0:4]  rd;
    logic [0:63] busW;
    logic        is64;
    logic        writeEnable;

    logic [0:4]  qa;
    logic [0:4]  qb;
    logic        hazA;
    logic        hazB;
    logic [0:3]  count;

    modport master (
        output ld_valid, ld_rd, ld_data, ld_is64,
        output fp_valid, fp_rd, fp_data, fp_is64,
        output qa, qb,
        input  fp_ready, rd, busW, is64, writeEnable, hazA, hazB, count
    );

    modport slave (
        input  ld_valid, ld_rd, ld_data, ld_is64,
        input  fp_valid, fp_rd, fp_data, fp_is64,
        input  qa, qb,
        output fp_ready, rd, busW, is64, writeEnable, hazA, hazB, count
    );
endinterface

// File: rtl/fp_wb_buffer.sv
// rtl/fp_wb_buffer.sv - FP register-file write-back buffer merging load path and FP-unit FIFO; optional FPWB_BYPASS_EN
module fp_wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    fp_wb_buffer_if.slave   bus
);
    localparam int         PW   = $clog2(DEPTH);
    localparam logic [0:3] FULL = 4'(DEPTH);

    logic [0:4]       q_rd   [DEPTH];
    logic [0:63]      q_data [DEPTH];
    logic [DEPTH-1:0] q_is64;
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [0:3]       cnt;

    logic ld_go;
    logic byp_go;
    logic push;
    logic pop;
    logic full;

    function automatic logic reg_match(input logic [0:4] r, input logic [0:4] erd, input logic e64);
        return e64 ? (r[0:3] == erd[0:3]) : (r == erd);
    endfunction

    // Control: load path wins the write port, then FIFO head, then (optionally) a bypassed FP result.
    always_comb begin
        full   = (cnt == FULL);
        ld_go  = bus.ld_valid & ~reset;
`ifdef FPWB_BYPASS_EN
        byp_go = ~reset & ~bus.ld_valid & (cnt == 4'd0) & bus.fp_valid;
`else
        byp_go = 1'b0;
`endif
        pop    = ~reset & ~bus.ld_valid & (cnt != 4'd0);
        push   = ~reset & bus.fp_valid & ~full & ~byp_go;
    end

    // Write-port mux, handshake and occupancy outputs.
    always_comb begin
        bus.writeEnable = 1'b0;
        bus.rd          = '0;
        bus.busW        = '0;
        bus.is64        = 1'b0;
        bus.fp_ready    = reset | ~full;
        bus.count       = reset ? 4'd0 : cnt;
        if (ld_go) begin
            bus.writeEnable = 1'b1;
            bus.rd          = bus.ld_rd;
            bus.busW        = bus.ld_data;
            bus.is64        = bus.ld_is64;
        end else if (pop) begin
            bus.writeEnable = 1'b1;
            bus.rd          = q_rd[head];
            bus.busW        = q_data[head];
            bus.is64        = q_is64[head];
        end else if (byp_go) begin
            bus.writeEnable = 1'b1;
            bus.rd          = bus.fp_rd;
            bus.busW        = bus.fp_data;
            bus.is64        = bus.fp_is64;
        end
    end

    // Hazard report: every held entry (head included) plus whatever is on the write port from outside the FIFO.
    always_comb begin
        bus.hazA = 1'b0;
        bus.hazB = 1'b0;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[i]) begin
                    bus.hazA = bus.hazA | reg_match(bus.qa, q_rd[i], q_is64[i]);
                    bus.hazB = bus.hazB | reg_match(bus.qb, q_rd[i], q_is64[i]);
                end
            end
            if (ld_go) begin
                bus.hazA = bus.hazA | reg_match(bus.qa, bus.ld_rd, bus.ld_is64);
                bus.hazB = bus.hazB | reg_match(bus.qb, bus.ld_rd, bus.ld_is64);
            end
            if (byp_go) begin
                bus.hazA = bus.hazA | reg_match(bus.qa, bus.fp_rd, bus.fp_is64);
                bus.hazB = bus.hazB | reg_match(bus.qb, bus.fp_rd, bus.fp_is64);
            end
        end
    end

    // FIFO state: enqueue at tail, dequeue at head, both may happen in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= 4'd0;
            q_valid <= '0;
        end else begin
            if (push) begin
                q_rd[tail]    <= bus.fp_rd;
                q_data[tail]  <= bus.fp_data;
                q_is64[tail]  <= bus.fp_is64;
                q_valid[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_wb_buffer.sv
// tb/tb_fp_wb_buffer.sv - randomized and directed self-checking bench for fp_wb_buffer
module tb_fp_wb_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_wb_buffer_if bus();

    fp_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [0:4]  rd;
        logic [0:63] data;
        logic        is64;
    } ent_t;

    ent_t mq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [0:4] r, input ent_t e);
        if (e.is64) return (r >> 1) == (e.rd >> 1);
        return r == e.rd;
    endfunction

    // Reference model: a plain queue of pending FP results; compared against the DUT every cycle.
    always @(negedge clk) begin
        ent_t        e;
        bit          we_e, byp, rdy_e, ha, hb;
        logic [0:4]  rd_e;
        logic [0:63] d_e;
        logic        w64_e;
        we_e = 0; byp = 0; rd_e = '0; d_e = '0; w64_e = 0; ha = 0; hb = 0;
        rdy_e = (mq.size() != DEPTH);
        if (reset) begin
            rdy_e = 1;
        end else begin
            if (bus.ld_valid) begin
                we_e = 1; rd_e = bus.ld_rd; d_e = bus.ld_data; w64_e = bus.ld_is64;
            end else if (mq.size() > 0) begin
                we_e = 1; rd_e = mq[0].rd; d_e = mq[0].data; w64_e = mq[0].is64;
            end
`ifdef FPWB_BYPASS_EN
            else if (bus.fp_valid) begin
                byp = 1; we_e = 1; rd_e = bus.fp_rd; d_e = bus.fp_data; w64_e = bus.fp_is64;
            end
`endif
            foreach (mq[i]) begin
                ha |= hit(bus.qa, mq[i]);
                hb |= hit(bus.qb, mq[i]);
            end
            if (bus.ld_valid || byp) begin
                e = '{rd: rd_e, data: d_e, is64: w64_e};
                ha |= hit(bus.qa, e);
                hb |= hit(bus.qb, e);
            end
        end
        chk("m_we",    64'(bus.writeEnable), 64'(we_e));
        chk("m_rd",    64'(bus.rd),          64'(rd_e));
        chk("m_busW",  64'(bus.busW),        64'(d_e));
        chk("m_is64",  64'(bus.is64),        64'(w64_e));
        chk("m_ready", 64'(bus.fp_ready),    64'(rdy_e));
        chk("m_count", 64'(bus.count),       64'(reset ? 0 : mq.size()));
        chk("m_hazA",  64'(bus.hazA),        64'(ha));
        chk("m_hazB",  64'(bus.hazB),        64'(hb));
        if (reset) begin
            mq.delete();
        end else begin
            bit do_push;
            do_push = bus.fp_valid && (mq.size() != DEPTH) && !byp;
            if (!bus.ld_valid && mq.size() > 0) void'(mq.pop_front());
            if (do_push) mq.push_back('{rd: bus.fp_rd, data: bus.fp_data, is64: bus.fp_is64});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.ld_valid = 0; bus.ld_rd = '0; bus.ld_data = '0; bus.ld_is64 = 0;
        bus.fp_valid = 0; bus.fp_rd = '0; bus.fp_data = '0; bus.fp_is64 = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        bus.qa = 5'd31; bus.qb = 5'd31;

        // reset held two cycles, then released
        step(); settle();
        step(); settle();
        chk("rst_we",    64'(bus.writeEnable), 64'd0);
        chk("rst_ready", 64'(bus.fp_ready),    64'd1);
        chk("rst_count", 64'(bus.count),       64'd0);
        step(); reset = 0; settle();
        chk("idle_we",    64'(bus.writeEnable), 64'd0);
        chk("idle_ready", 64'(bus.fp_ready),    64'd1);

        // single FP result
        step();
        bus.fp_valid = 1; bus.fp_rd = 5'd6; bus.fp_data = 64'h0000_0000_3F80_0000; bus.fp_is64 = 0;
        settle();
`ifdef FPWB_BYPASS_EN
        chk("fp1_byp_we", 64'(bus.writeEnable), 64'd1);
        chk("fp1_byp_rd", 64'(bus.rd),          64'd6);
`else
        chk("fp1_we0", 64'(bus.writeEnable), 64'd0);
`endif
        step(); idle_inputs(); settle();
`ifndef FPWB_BYPASS_EN
        chk("fp1_we",   64'(bus.writeEnable), 64'd1);
        chk("fp1_rd",   64'(bus.rd),          64'd6);
        chk("fp1_busW", 64'(bus.busW),        64'h0000_0000_3F80_0000);
`endif
        step(); settle();
        chk("fp1_count", 64'(bus.count), 64'd0);

        // load priority and starvation
        for (int i = 1; i <= 5; i++) begin
            step();
            bus.ld_valid = 1; bus.ld_rd = 5'($urandom_range(16, 31)); bus.ld_data = {$urandom, $urandom};
            bus.ld_is64 = 0;
            bus.fp_valid = (i <= 4); bus.fp_rd = 5'(i); bus.fp_data = 64'(i * 100); bus.fp_is64 = 0;
            settle();
            chk("st_ld_we", 64'(bus.writeEnable), 64'd1);
            chk("st_ld_rd", 64'(bus.rd),          64'(bus.ld_rd));
            if (i == 5) begin
                chk("st_ready0", 64'(bus.fp_ready), 64'd0);
                chk("st_count4", 64'(bus.count),    64'd4);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            step(); idle_inputs(); settle();
            chk("st_drain_we", 64'(bus.writeEnable), 64'd1);
            chk("st_drain_rd", 64'(bus.rd),          64'(i));
        end

        // full FIFO with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            step();
            bus.ld_valid = 1; bus.ld_rd = 5'd20; bus.ld_data = 64'h55;
            bus.fp_valid = 1; bus.fp_rd = 5'(10 + i); bus.fp_data = 64'(i);
            settle();
        end
        step();
        bus.ld_valid = 0; bus.fp_valid = 1; bus.fp_rd = 5'd30;
        settle();
        chk("full_ready0", 64'(bus.fp_ready), 64'd0);
        chk("full_pop_rd", 64'(bus.rd),       64'd10);
        step(); idle_inputs(); settle();
        chk("full_count3", 64'(bus.count),    64'd3);
        chk("full_ready1", 64'(bus.fp_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin step(); settle(); end

        // 64-bit hazard on a queued pair
        step();
        bus.ld_valid = 1; bus.ld_rd = 5'd20; bus.ld_is64 = 0;
        bus.fp_valid = 1; bus.fp_rd = 5'd8; bus.fp_is64 = 1; bus.fp_data = 64'hDEAD_BEEF_0000_0001;
        settle();
        step();
        bus.fp_valid = 0; bus.qa = 5'd9; bus.qb = 5'd10;
        settle();
        chk("haz64_A", 64'(bus.hazA), 64'd1);
        chk("haz64_B", 64'(bus.hazB), 64'd0);
        step(); bus.ld_valid = 0; settle();
        chk("haz64_drain_is64", 64'(bus.is64), 64'd1);
        chk("haz64_drain_A",    64'(bus.hazA), 64'd1);
        step(); settle();
        chk("haz64_after_A", 64'(bus.hazA), 64'd0);

        // reset mid-stream
        for (int i = 0; i < 3; i++) begin
            step();
            bus.ld_valid = 1; bus.ld_rd = 5'd25;
            bus.fp_valid = 1; bus.fp_rd = 5'(3 + i); bus.fp_is64 = 0;
            settle();
        end
        step();
        reset = 1; bus.fp_valid = 0; bus.qa = 5'd3;
        settle();
        chk("mrst_we",   64'(bus.writeEnable), 64'd0);
        chk("mrst_hazA", 64'(bus.hazA),        64'd0);
        step(); reset = 0; idle_inputs(); settle();
        chk("mrst_count", 64'(bus.count),       64'd0);
        chk("mrst_we1",   64'(bus.writeEnable), 64'd0);
        step(); settle();
        chk("mrst_we2",   64'(bus.writeEnable), 64'd0);

`ifdef FPWB_BYPASS_EN
        step();
        bus.fp_valid = 1; bus.fp_rd = 5'd2; bus.fp_is64 = 0; bus.qa = 5'd2;
        settle();
        chk("byp_we",   64'(bus.writeEnable), 64'd1);
        chk("byp_rd",   64'(bus.rd),          64'd2);
        chk("byp_hazA", 64'(bus.hazA),        64'd1);
        step(); idle_inputs(); settle();
`endif

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step();
            reset        = ($urandom_range(0, 99) == 0);
            bus.ld_valid = ($urandom_range(0, 99) < 30);
            bus.ld_rd    = 5'($urandom_range(0, 7));
            bus.ld_data  = {$urandom, $urandom};
            bus.ld_is64  = 1'($urandom);
            bus.fp_valid = ($urandom_range(0, 99) < 60);
            bus.fp_rd    = 5'($urandom_range(0, 7));
            bus.fp_data  = {$urandom, $urandom};
            bus.fp_is64  = 1'($urandom);
            bus.qa       = 5'($urandom_range(0, 9));
            bus.qb       = 5'($urandom_range(0, 9));
            settle();
        end
        step(); reset = 0; idle_inputs();
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_wb_buffer.md
# fp_wb_buffer

Write-back buffer feeding the single write port of the floating-point register file. Merges two producers: the load/movi2fp path from MEM/WB, which can never be stalled, and the multi-cycle FP arithmetic unit, which uses a valid/ready handshake. FP results are queued in a small FIFO and drained into the register file one write per cycle, with the load path taking priority. The block also reports pending destination registers to decode so RAW/WAW hazards on queued writes can be stalled.

## Interface
- DEPTH, 4: FIFO entries for FP-unit results; power of two, 2..8.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_valid  in  1  load/movi2fp write request this cycle; always accepted.
- ld_rd  in  [0:4]  destination register.
- ld_data  in  [0:63]  write data; 32-bit values are in [32:63].
- ld_is64  in  1  1 = write the register pair rd[0:3]*2, rd[0:3]*2+1.
- fp_valid  in  1  FP-unit result offered.
- fp_ready  out  1  buffer accepts the FP result this cycle.
- fp_rd, fp_data, fp_is64  in  [0:4], [0:63], 1  same meaning as the ld_* signals.
- rd  out  [0:4]  register-file destination.
- busW  out  [0:63]  register-file write data.
- is64  out  1  register-file 64-bit write select.
- writeEnable  out  1  register-file write strobe.
- qa, qb  in  [0:4]  decode source/destination register numbers to check.
- hazA, hazB  out  1  a write to qa/qb is pending.
- count  out  [0:3]  FIFO occupancy.

## Operation
- FIFO: circular buffer of DEPTH entries {rd, data, is64}, with head/tail pointers and an occupancy counter. Pointers wrap modulo DEPTH.
- Push: fp_valid & fp_ready. fp_ready = (count != DEPTH). A full FIFO deasserts ready even if a pop occurs in the same cycle; there is no pass-through when full.
- Write-port selection (combinational from state and ld_*):
  - If ld_valid: drive ld_rd, ld_data, ld_is64, with writeEnable=1. The head is not popped.
  - Else if count != 0: drive the head entry with writeEnable=1, and pop it this cycle.
  - Else: writeEnable=0. rd, busW and is64 are driven as 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Hazard match for a register r against an entry e:
  - If e.is64: match when r[0:3] == e.rd[0:3].
  - Otherwise: match when r == e.rd.
- hazA = match(qa) over all valid FIFO entries, including the head being written this cycle, OR'd with the ld_* entry when ld_valid. hazB is the same for qb.
- Ordering between the two producers is guaranteed upstream by decode stalling on hazA/hazB. The buffer itself does not reorder or drop entries.
- An is64 entry with odd rd writes the pair rd[0:3]. The register file ignores rd[4] in 64-bit mode.

## Timing
- Load-path latency: 0. The write occurs at the clock edge ending the cycle in which ld_valid is presented.
- FP-path latency: the entry is written at the earliest edge after the push edge on which ld_valid=0. Minimum latency is 1 cycle.
- Continuous ld_valid starves the FIFO, which holds its contents. fp_ready falls once DEPTH entries are held.
- Reset, synchronous, including mid-operation: all queued entries are discarded, count=0, pointers=0.
- Output values during and after reset: writeEnable=0, rd=0, busW=0, is64=0, fp_ready=1, count=0, hazA=hazB=0. The hazard outputs also depend on ld_valid; ld_* inputs are ignored while reset is high.

## Configuration
- FPWB_BYPASS_EN defined: when count==0, ld_valid=0 and fp_valid=1, the FP result is written straight to the register file in the same cycle with no push. Latency is 0.
  - In this case fp_valid/fp_rd also contribute to hazA/hazB.
  - fp_ready stays = (count != DEPTH).
- Not defined: every FP result goes through the FIFO, with a minimum latency of 1 cycle. fp_* inputs never affect the write port or the hazard outputs combinationally.

## Test plan
- Reset then idle:
  - reset held 2 cycles -> writeEnable=0, fp_ready=1, count=0.
  - Release -> outputs unchanged.
- FP single result, bypass off: push rd=6, data=0x0000_0000_3F80_0000, is64=0 -> next cycle writeEnable=1, rd=6, busW as pushed; the cycle after, count=0.
- Load priority / starvation: push 4 FP results (rd 1..4) while ld_valid=1 for 5 cycles:
  - fp_ready=0 after the 4th push.
  - Load writes occur each cycle.
  - After ld_valid drops, FP writes appear in order 1,2,3,4 on consecutive cycles.
- Full with simultaneous pop: count=DEPTH, ld_valid=0, fp_valid=1:
  - fp_ready=0 and no push occurs.
  - Next cycle count=3 and fp_ready=1.
- Hazard, 64-bit: queued entry rd=8, is64=1:
  - qa=9 -> hazA=1; qb=10 -> hazB=0.
  - After the entry drains -> hazA=0.
- Reset mid-stream: 3 entries queued, reset for 1 cycle -> count=0 with no further writeEnable pulses. Bypass build only: with an empty FIFO, fp_valid rd=2 -> writeEnable=1 with rd=2 in the same cycle and hazA=1 for qa=2.
